backprop_neuron_seq: RTL and testbench
======================================

// Module: backprop_neuron_seq
// PURPOSE
//  Sequential, parametrised back-propagation engine for one neuron with N_IN synapses.
//  Holds the neuron's weight vector internally and processes one weight per cycle on a start/done handshake.
//  Per synapse i it produces the error passed back to the upstream neuron and an updated weight.
//  Sits between a neuron's forward datapath and the layer-level training sequencer.
// PARAMETERS
//  N_IN        4     number of synapses (>=1); IDX_W = $clog2(N_IN) (min 1), localparam
//  INIT_WEIGHT 0.0   real; value loaded into every weight on reset
//  MOMENTUM    0.5   real; momentum coefficient, used only when BP_MOMENTUM_EN is defined
// PORTS
//  clk           in   1          clock; all state updates on posedge
//  rst_n         in   1          asynchronous, active-low reset
//  start         in   1          request a back-prop pass; sampled in IDLE only
//  axon          in   real       neuron output (sigmoid value) of the forward pass
//  back_prop     in   real       error arriving from downstream
//  ratio         in   real       learning rate
//  previous      in   real[N_IN] upstream axon values feeding each synapse
//  load_en       in   1          write load_weight into weight[load_idx]
//  load_idx      in   IDX_W      weight index for load
//  load_weight   in   real       weight value to load
//  busy          out  1          high from the cycle after start acceptance until done
//  done          out  1          one-cycle pulse when the pass completes
//  weight_out    out  real[N_IN] current weight vector (registered)
//  bp_out        out  real[N_IN] back-prop error per synapse (registered)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, busy=0, done=0, idx=0, all weight = INIT_WEIGHT,
//   all bp_out = 0.0, latched inputs = 0.0; reset mid-pass aborts it, partial updates are discarded.
//  FSM: IDLE -> SHIFT -> UPDATE (N_IN cycles) -> DONE -> IDLE.
//  IDLE: if start=1, latch axon, back_prop, ratio and previous[], go to SHIFT. start ignored in other states.
//  SHIFT: cur_shift = (1.0-axon_l)*axon_l*back_prop_l; idx=0; busy=1.
//  UPDATE, one synapse per cycle, i=idx:
//   bp_out[i] <= cur_shift*weight[i]     (uses the pre-update weight)
//   delta_i    = cur_shift*previous_l[i]*ratio_l
//   weight[i] <= weight[i] + delta_i
//   idx wraps: at idx==N_IN-1 go to DONE, otherwise idx+1.
//  DONE: done=1 for exactly one cycle, busy=0, return to IDLE.
//  Latency: start sampled at edge t -> done high during cycle t+N_IN+2; back-to-back start is
//   accepted in the cycle after done, giving a throughput of one pass per N_IN+3 cycles.
//  Loads: load_en is honoured only in IDLE; during SHIFT/UPDATE/DONE it is ignored (no queueing).
//   start and load_en asserted together in IDLE: the load is applied and start is accepted; the pass uses the loaded weight.
//   load_idx >= N_IN: the load is ignored.
//  bp_out[i] and weight_out hold their values between passes; unprocessed entries keep their old values.
//  Inputs are latched at acceptance; changes to them during a pass have no effect.
// CONFIGURATION
//  BP_MOMENTUM_EN defined: per-synapse register prev_delta[i] (reset 0.0);
//   delta_i = cur_shift*previous_l[i]*ratio_l + MOMENTUM*prev_delta[i]; prev_delta[i] <= delta_i.
//   A load to weight[i] clears prev_delta[i].
//  BP_MOMENTUM_EN undefined: no prev_delta storage and MOMENTUM is unused; delta_i is as above.
// TESTING
//  T1 reset: rst_n=0 with INIT_WEIGHT=0.0 -> weight_out all 0.0, bp_out all 0.0, busy=0, done=0.
//  T2 single pass: N_IN=4; load weights {2.0,-1.0,0.5,0.0}; axon=0.5, back_prop=1.0, ratio=0.1, previous all 1.0;
//   pulse start -> cur_shift=0.25, bp_out={0.5,-0.25,0.125,0.0}, weight={2.025,-0.975,0.525,0.025},
//   done exactly 6 cycles after the start edge.
//  T3 busy protection: during UPDATE, pulse start and load_en(idx=1,-9.0) -> both ignored; a single done pulse;
//   weight[1] = -0.975.
//  T4 simultaneous: in IDLE, load_en(idx=0,1.0) and start in the same cycle with T2 inputs -> bp_out[0]=0.25,
//   weight[0]=1.025.
//  T5 reset mid-pass: drop rst_n at idx=2 -> immediate IDLE, weights=INIT_WEIGHT, no done pulse.
//  T6 BP_MOMENTUM_EN defined, MOMENTUM=0.5: two T2 passes from weight 2.0 -> after pass 1 weight=2.025;
//   pass 2 uses cur_shift=0.25 (axon unchanged), delta=0.025+0.0125=0.0375 -> weight=2.0625.

Source files
------------

// File: rtl/backprop_neuron_seq.sv
// rtl/backprop_neuron_seq.sv - sequential single-neuron back-prop engine, one synapse per cycle
// Optional momentum term enabled by defining BP_MOMENTUM_EN.
module backprop_neuron_seq #(
  parameter int  N_IN        = 4,
  parameter real INIT_WEIGHT = 0.0,
  parameter real MOMENTUM    = 0.5,
  localparam int IDX_W       = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  real              i_axon,
  input  real              i_back_prop,
  input  real              i_ratio,
  input  real              i_previous   [N_IN],
  input  logic             i_load_en,
  input  logic [IDX_W-1:0] i_load_idx,
  input  real              i_load_weight,
  output logic             o_busy,
  output logic             o_done,
  output real              o_weight_out [N_IN],
  output real              o_bp_out     [N_IN]
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_UPDATE, S_DONE} state_t;

  localparam logic [IDX_W:0]   N_IN_W = (IDX_W+1)'(N_IN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [IDX_W-1:0] r_idx;
  real              r_axon;
  real              r_back_prop;
  real              r_ratio;
  real              r_cur_shift;
  real              r_previous [N_IN];
  real              r_weight   [N_IN];
  real              r_bp       [N_IN];
  real              w_delta;
  logic             w_load_ok;
`ifdef BP_MOMENTUM_EN
  real              r_prev_delta [N_IN];
`endif

  assign w_load_ok    = ({1'b0, i_load_idx} < N_IN_W);
  assign o_weight_out = r_weight;
  assign o_bp_out     = r_bp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    case (r_state)
      S_IDLE:   if (i_start) w_next_state = S_SHIFT;
      S_SHIFT: begin
        o_busy       = 1'b1;
        w_next_state = S_UPDATE;
      end
      S_UPDATE: begin
        o_busy = 1'b1;
        if (r_idx == LAST_IDX) w_next_state = S_DONE;
      end
      S_DONE: begin
        o_done       = 1'b1;
        w_next_state = S_IDLE;
      end
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_delta = r_cur_shift * r_previous[r_idx] * r_ratio;
`ifdef BP_MOMENTUM_EN
    w_delta = w_delta + MOMENTUM * r_prev_delta[r_idx];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= '0;
      r_axon      <= 0.0;
      r_back_prop <= 0.0;
      r_ratio     <= 0.0;
      r_cur_shift <= 0.0;
      for (int i = 0; i < N_IN; i++) begin
        r_previous[i] <= 0.0;
        r_weight[i]   <= INIT_WEIGHT;
        r_bp[i]       <= 0.0;
`ifdef BP_MOMENTUM_EN
        r_prev_delta[i] <= 0.0;
`endif
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          // A load in the acceptance cycle lands before UPDATE reads the weight.
          if (i_load_en && w_load_ok) begin
            r_weight[i_load_idx] <= i_load_weight;
`ifdef BP_MOMENTUM_EN
            r_prev_delta[i_load_idx] <= 0.0;
`endif
          end
          if (i_start) begin
            r_axon      <= i_axon;
            r_back_prop <= i_back_prop;
            r_ratio     <= i_ratio;
            for (int i = 0; i < N_IN; i++) r_previous[i] <= i_previous[i];
          end
        end
        S_SHIFT: begin
          r_cur_shift <= (1.0 - r_axon) * r_axon * r_back_prop;
          r_idx       <= '0;
        end
        S_UPDATE: begin
          r_bp[r_idx]     <= r_cur_shift * r_weight[r_idx];
          r_weight[r_idx] <= r_weight[r_idx] + w_delta;
`ifdef BP_MOMENTUM_EN
          r_prev_delta[r_idx] <= w_delta;
`endif
          r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_backprop_neuron_seq.sv
// tb/tb_backprop_neuron_seq.sv - directed plus randomized bench for backprop_neuron_seq
module tb_backprop_neuron_seq;

  localparam int  N   = 4;
  localparam real MOM = 0.5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  real        axon = 0.0;
  real        back_prop = 0.0;
  real        ratio = 0.0;
  real        previous [N];
  logic       load_en = 1'b0;
  logic [1:0] load_idx = '0;
  real        load_weight = 0.0;
  logic       busy;
  logic       done;
  real        weight_out [N];
  real        bp_out [N];

  int vectors = 0;
  int miscompares = 0;

  real m_w [N];
  real m_bp [N];
  real m_pd [N];
  real m_p [N];

  backprop_neuron_seq #(.N_IN(N), .INIT_WEIGHT(0.0), .MOMENTUM(MOM)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_axon(axon), .i_back_prop(back_prop),
    .i_ratio(ratio), .i_previous(previous), .i_load_en(load_en), .i_load_idx(load_idx),
    .i_load_weight(load_weight), .o_busy(busy), .o_done(done),
    .o_weight_out(weight_out), .o_bp_out(bp_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_real(input string tag, input real obs, input real exp);
    bit ok;
    ok = ((obs - exp) < 1e-9) && ((exp - obs) < 1e-9);
    vectors++;
    assert (ok === 1'b1) else begin
      miscompares++;
      $error("FAIL %s observed=%0.9f expected=%0.9f", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_arrays(input string tag);
    for (int i = 0; i < N; i++) begin
      check_real($sformatf("%s weight[%0d]", tag, i), weight_out[i], m_w[i]);
      check_real($sformatf("%s bp_out[%0d]", tag, i), bp_out[i], m_bp[i]);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_w[i] = 0.0; m_bp[i] = 0.0; m_pd[i] = 0.0;
    end
  endtask

  task automatic do_load(input int idx, input real w);
    load_en = 1'b1; load_idx = 2'(idx); load_weight = w;
    tick();
    load_en = 1'b0;
    m_w[idx] = w;
    m_pd[idx] = 0.0;
  endtask

  // Reference: one full pass computed straight from the update rules.
  task automatic model_pass(input real a, input real b, input real r);
    real cs, d;
    cs = (1.0 - a) * a * b;
    for (int i = 0; i < N; i++) begin
      m_bp[i] = cs * m_w[i];
      d = cs * m_p[i] * r;
`ifdef BP_MOMENTUM_EN
      d = d + MOM * m_pd[i];
`endif
      m_pd[i] = d;
      m_w[i] = m_w[i] + d;
    end
  endtask

  task automatic run_pass(input string tag, input real a, input real b, input real r,
                          input bit with_load, input int lidx, input real lw, input bit poke);
    axon = a; back_prop = b; ratio = r;
    for (int i = 0; i < N; i++) previous[i] = m_p[i];
    start = 1'b1;
    if (with_load) begin
      load_en = 1'b1; load_idx = 2'(lidx); load_weight = lw;
      m_w[lidx] = lw; m_pd[lidx] = 0.0;
    end
    tick();
    start = 1'b0; load_en = 1'b0;
    model_pass(a, b, r);
    axon = 0.9; back_prop = -3.0; ratio = 7.0;
    for (int i = 0; i < N; i++) previous[i] = 5.0;
    check_bit({tag, " busy@0"}, busy, 1'b1);
    check_bit({tag, " done@0"}, done, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      if (poke && k == 3) begin
        start = 1'b1; load_en = 1'b1; load_idx = 2'd1; load_weight = -9.0;
      end
      if (poke && k == 4) begin
        start = 1'b0; load_en = 1'b0;
      end
      tick();
      check_bit($sformatf("%s busy@%0d", tag, k), busy, (k <= 4));
      check_bit($sformatf("%s done@%0d", tag, k), done, (k == 5));
    end
    check_arrays(tag);
  endtask

  initial begin
    int pulses;
    real a, b, r;
    for (int i = 0; i < N; i++) begin
      previous[i] = 0.0; m_p[i] = 0.0;
    end
    model_reset();

    // T1 reset
    #12;
    check_bit("reset busy", busy, 1'b0);
    check_bit("reset done", done, 1'b0);
    check_arrays("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    // T2 single pass
    do_load(0, 2.0); do_load(1, -1.0); do_load(2, 0.5); do_load(3, 0.0);
    for (int i = 0; i < N; i++) m_p[i] = 1.0;
    run_pass("T2", 0.5, 1.0, 0.1, 1'b0, 0, 0.0, 1'b0);
    check_real("T2 w0 const", weight_out[0], 2.025);
    check_real("T2 bp1 const", bp_out[1], -0.25);

    // T3 start/load during UPDATE ignored
    do_load(0, 2.0); do_load(1, -1.0); do_load(2, 0.5); do_load(3, 0.0);
    run_pass("T3", 0.5, 1.0, 0.1, 1'b0, 0, 0.0, 1'b1);
    check_real("T3 w1 const", weight_out[1], -0.975);
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      pulses += int'(done);
    end
    check_int("T3 extra done pulses", pulses, 0);

    // T4 load and start together
    do_load(1, -1.0); do_load(2, 0.5); do_load(3, 0.0);
    run_pass("T4", 0.5, 1.0, 0.1, 1'b1, 0, 1.0, 1'b0);
    check_real("T4 bp0 const", bp_out[0], 0.25);

    // Randomized passes
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < N; i++) begin
        do_load(i, real'($urandom_range(0, 4000)) / 1000.0 - 2.0);
        m_p[i] = real'($urandom_range(0, 2000)) / 1000.0 - 1.0;
      end
      a = real'($urandom_range(0, 1000)) / 1000.0;
      b = real'($urandom_range(0, 2000)) / 1000.0 - 1.0;
      r = real'($urandom_range(0, 500)) / 1000.0;
      run_pass($sformatf("R%0d", n), a, b, r, n[0], int'($urandom_range(0, N-1)),
               real'($urandom_range(0, 2000)) / 1000.0 - 1.0, 1'b0);
    end

    // Second pass without reloading exercises held weights (and momentum if built in)
    run_pass("RH", 0.5, 1.0, 0.1, 1'b0, 0, 0.0, 1'b0);

    // T5 reset mid-pass at idx 2
    for (int i = 0; i < N; i++) m_p[i] = 1.0;
    axon = 0.5; back_prop = 1.0; ratio = 0.1;
    for (int i = 0; i < N; i++) previous[i] = 1.0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_bit("T5 busy", busy, 1'b0);
    check_bit("T5 done", done, 1'b0);
    check_arrays("T5");
    tick(); tick();
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      pulses += int'(done);
    end
    check_int("T5 done pulses", pulses, 0);
    check_arrays("T5 after");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
